// File: rtl/alu_result_buf_if.sv
// Handshake bundle between the ALU, the result buffer and writeback.
// The master side is the producer/consumer pair; the slave side is the buffer.
interface alu_result_buf_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 2
);
   logic                         in_valid;
   logic                         in_ready;
   logic [WIDTH-1:0]             in_out;
   logic                         in_carry;
   logic                         out_valid;
   logic                         out_ready;
   logic [WIDTH-1:0]             out_data;
   logic                         out_carry;
   logic                         out_zero;
   logic [$clog2(DEPTH+1)-1:0]   count;
   logic                         clr_carry;
   logic                         carry_seen;

   modport master (
      output in_valid, in_out, in_carry, out_ready, clr_carry,
      input  in_ready, out_valid, out_data, out_carry, out_zero, count, carry_seen
   );

   modport slave (
      input  in_valid, in_out, in_carry, out_ready, clr_carry,
      output in_ready, out_valid, out_data, out_carry, out_zero, count, carry_seen
   );
endinterface

// File: rtl/alu_result_buf.sv
// Small FIFO holding ALU results (data, carry, zero) until writeback takes them,
// plus a sticky carry flag for the control unit.
module alu_result_buf #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 2
) (
   input logic             clk,
   input logic             rst_n,
   alu_result_buf_if.slave bus
);
   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             carry;
      logic             zero;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          wr_entry;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            carry_seen_q, carry_seen_d;
   logic            full, empty, push, pop;

   assign full  = (count_q == FullCnt);
   assign empty = (count_q == '0);
   // Handshakes depend only on registered occupancy; no out_ready -> in_ready path.
   assign push  = bus.in_valid && !full;
   assign pop   = !empty && bus.out_ready;

   always_comb begin
      wr_entry.data  = bus.in_out;
      wr_entry.carry = bus.in_carry;
      wr_entry.zero  = (bus.in_out == '0);
   end

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      carry_seen_d = (carry_seen_q && !bus.clr_carry) || (push && bus.in_carry);
      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         carry_seen_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         carry_seen_q <= carry_seen_d;
      end
   end

   // Storage is not reset; stale entries are masked by count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_entry;
      end
   end

   always_comb begin
      bus.in_ready   = !full;
      bus.out_valid  = !empty;
      bus.count      = count_q;
      bus.carry_seen = carry_seen_q;
      bus.out_data   = '0;
      bus.out_carry  = 1'b0;
      bus.out_zero   = 1'b0;
      if (!empty) begin
         bus.out_data  = mem_q[rd_ptr_q].data;
         bus.out_carry = mem_q[rd_ptr_q].carry;
         bus.out_zero  = mem_q[rd_ptr_q].zero;
      end
   end
endmodule

// File: tb/tb_alu_result_buf.sv
// Randomized scoreboard bench for alu_result_buf: a reference queue model predicts
// occupancy, flags and the in-order result stream.
module tb_alu_result_buf;
   localparam int unsigned WIDTH = 4;
   localparam int unsigned DEPTH = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   alu_result_buf_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   alu_result_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [WIDTH+1:0] exp_q [$];   // {data, carry, zero} expected at the head, in order
   logic [WIDTH:0]   src_q [$];   // {carry, data} waiting to be offered by the ALU
   logic             m_carry = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: occupancy is the length of the expected-result queue.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         m_carry = 1'b0;
      end else begin
         automatic int  occ    = exp_q.size();
         automatic bit  m_push = bus.in_valid && (occ < DEPTH);
         check("count", 32'(bus.count), 32'(occ));
         check("in_ready", 32'(bus.in_ready), 32'(occ < DEPTH));
         check("out_valid", 32'(bus.out_valid), 32'(occ != 0));
         check("carry_seen", 32'(bus.carry_seen), 32'(m_carry));
         m_carry = (m_carry && !bus.clr_carry) || (m_push && bus.in_carry);
         if (m_push) exp_q.push_back({bus.in_out, bus.in_carry, bus.in_out == '0});
      end
   end

   // Monitor: compares the head whenever writeback takes it.
   always @(negedge clk) begin
      #1;
      if (rst_n) begin
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_pop", 32'(bus.out_valid), 32'(0));
            end else begin
               check("head", 32'({bus.out_data, bus.out_carry, bus.out_zero}),
                     32'(exp_q.pop_front()));
            end
         end else if (!bus.out_valid) begin
            check("idle_outputs", 32'({bus.out_data, bus.out_carry, bus.out_zero}), 32'(0));
         end
      end
   end

   task automatic add(input logic [WIDTH-1:0] d, input logic c);
      src_q.push_back({c, d});
   endtask

   // One clock of stimulus; the ALU holds its result until accepted.
   task automatic cycle(input bit v_en, input bit ordy, input bit clr);
      bit acc;
      bus.in_valid = v_en && (src_q.size() > 0);
      if (bus.in_valid) begin
         {bus.in_carry, bus.in_out} = src_q[0];
      end else begin
         bus.in_out   = WIDTH'($urandom);
         bus.in_carry = 1'($urandom);
      end
      bus.out_ready = ordy;
      bus.clr_carry = clr;
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (acc) void'(src_q.pop_front());
      #1;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_out    = '0;
      bus.in_carry  = 1'b0;
      bus.out_ready = 1'b0;
      bus.clr_carry = 1'b0;
      #2;
      check("rst_out_valid", 32'(bus.out_valid), 32'(0));
      check("rst_in_ready", 32'(bus.in_ready), 32'(1));
      check("rst_count", 32'(bus.count), 32'(0));
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // Basic capture: zero result then carry result.
      add(4'b0000, 1'b0);
      add(4'b0010, 1'b1);
      repeat (4) cycle(1, 1, 0);

      // Backpressure: three results against a stalled writeback, then drain.
      add(4'h3, 1'b0);
      add(4'h5, 1'b1);
      add(4'h6, 1'b0);
      repeat (4) cycle(1, 0, 0);
      repeat (5) cycle(1, 1, 0);

      // Simultaneous push/pop at count 1, pointers wrapping.
      for (int i = 0; i < 8; i++) add(WIDTH'(i), 1'b0);
      repeat (10) cycle(1, 1, 0);

      // Sticky flag: clear alone, then clear together with a carry push.
      cycle(0, 1, 1);
      cycle(0, 1, 0);
      add(4'h7, 1'b1);
      cycle(1, 1, 1);
      cycle(0, 1, 0);

      // Empty pop.
      repeat (3) cycle(0, 1, 0);

      // Reset mid-operation with two entries held.
      add(4'h9, 1'b1);
      add(4'hA, 1'b0);
      repeat (3) cycle(1, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(bus.out_valid), 32'(0));
      check("mid_rst_count", 32'(bus.count), 32'(0));
      check("mid_rst_carry_seen", 32'(bus.carry_seen), 32'(0));
      check("mid_rst_in_ready", 32'(bus.in_ready), 32'(1));
      check("mid_rst_out_data", 32'(bus.out_data), 32'(0));
      src_q.delete();
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      add(4'b0101, 1'b0);
      cycle(1, 0, 0);
      check("post_rst_count", 32'(bus.count), 32'(1));
      check("post_rst_data", 32'(bus.out_data), 32'(4'b0101));
      repeat (2) cycle(0, 1, 0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         if (src_q.size() < 3) add(WIDTH'($urandom), 1'($urandom));
         cycle($urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0,
               $urandom_range(7, 0) == 0);
      end
      repeat (6) cycle(0, 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_result_buf.md
# alu_result_buf

Registered result buffer that sits directly downstream of the ALU (mult/add/logic ops). It captures each 4-bit ALU result with its carry, derives a zero flag, and holds results in a small FIFO until writeback accepts them, so a stalled writeback never loses a result. It also keeps a sticky carry flag for the control unit.

## Interface
Parameters:
- WIDTH, 4, ALU result width in bits.
- DEPTH, 2, number of FIFO entries. Must be a power of two and at least 2.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  the ALU presents a result this cycle.
- in_ready  out  1  the buffer can accept a result; equals !full.
- in_out  in  WIDTH  ALU result (the multop `out`).
- in_carry  in  1  ALU carry (the multop `carry`).
- out_valid  out  1  the head entry is valid.
- out_ready  in  1  writeback accepts the head entry.
- out_data  out  WIDTH  head entry result.
- out_carry  out  1  head entry carry.
- out_zero  out  1  head entry result equals 0.
- count  out  $clog2(DEPTH+1)  number of occupied entries.
- clr_carry  in  1  synchronous clear of carry_seen.
- carry_seen  out  1  sticky; set by any accepted result with carry=1.

## Operation
- Push: occurs when in_valid && in_ready. The entry stores {in_out, in_carry, in_out==0} at wr_ptr. wr_ptr increments and wraps modulo DEPTH.
- Pop: occurs when out_valid && out_ready. rd_ptr increments and wraps modulo DEPTH.
- Occupancy:
  - count +1 on push only.
  - count −1 on pop only.
  - count unchanged on simultaneous push and pop.
- Full: count==DEPTH, which forces in_ready=0. in_ready does not depend on out_ready, so there is no push while full even if a pop occurs in the same cycle.
- Empty: count==0, which forces out_valid=0. There is no combinational bypass.
- out_valid = (count!=0).
- out_data, out_carry and out_zero come from the head entry. They are forced to 0 when out_valid=0.
- in_valid when in_ready=0: the ALU must hold its data. The buffer ignores the input and keeps its state unchanged.
- carry_seen:
  - next = (carry_seen && !clr_carry) || (push && in_carry).
  - Set wins over a simultaneous clear.
- No arithmetic is performed on data. The zero flag is a full-width compare and is computed at push time.
- Reset (asynchronous, any time, including mid-transfer):
  - Pointers and count go to 0, and carry_seen goes to 0.
  - Outputs: out_valid=0, out_data=0, out_carry=0, out_zero=0, in_ready=1, count=0.
  - Entries in flight are discarded.
  - Storage contents need no reset; they are masked by count.

## Timing
- Latency: a result pushed at edge N is visible on out_* after edge N (out_valid=1 in cycle N+1). Minimum latency is 1 cycle.
- Throughput: 1 result per cycle when out_ready is held high.
- in_ready and out_valid are derived from registered count only. There is no combinational path from out_ready to in_ready.
- count, carry_seen and the head outputs update only on clock edges, except on reset assertion, which takes effect immediately.
- Release of rst_n is synchronous to clk as handled by the top level. The first push can occur at the first edge after release.

## Test plan
- Reset mid-operation:
  - Stimulus: push 2 entries, then assert rst_n=0 between edges.
  - Response: out_valid, count and carry_seen go to 0 immediately; in_ready=1.
  - After release, the next push of 4'b0101 appears with count=1.
- Basic capture:
  - Stimulus: push {0000, c=0} (0*15), then {0010, c=1} (9*2), with out_ready=1.
  - Response:
    - Cycle N+1: out_data=0000, out_zero=1, out_carry=0.
    - Cycle N+2: out_data=0010, out_zero=0, out_carry=1.
    - carry_seen=1 from cycle N+2 on.
- Backpressure/full:
  - Stimulus: out_ready=0, in_valid=1 with 3 different results.
  - Response:
    - count reaches 2 and in_ready=0.
    - The third result is held, not stored.
    - Raising out_ready pops entries in order.
    - The third result is accepted the cycle after count drops to 1.
- Simultaneous push/pop at count=1:
  - Response: count stays 1, data order is preserved, and pointers wrap correctly over 8 consecutive transfers (pattern 0..7 out in order).
- Sticky flag:
  - Clear only: clr_carry=1 with no push gives carry_seen=0 next cycle.
  - Clear with carry push: clr_carry=1 in the same cycle as a push with carry=1 gives carry_seen=1.
- Empty pop:
  - Stimulus: out_ready=1 with count=0.
  - Response: no state change; out_* stay 0.
